// File: rtl/ycbcr_pkg.sv
// Shared colour-space constants (Q16) for the forward RGB->YCbCr and inverse YCbCr->RGB CSD paths.
package ycbcr_pkg;

    localparam int unsigned K_SCALE       = 16;
    localparam int unsigned CHROMA_OFFSET = 128;
    localparam int unsigned ROUND_HALF    = 1 << (K_SCALE - 1);

    // Inverse path: R = Y + K_RCR*dCr, G = Y - K_GCB*dCb - K_GCR*dCr, B = Y + K_BCB*dCb
    localparam int unsigned K_RCR = 91881;
    localparam int unsigned K_GCB = 22554;
    localparam int unsigned K_GCR = 46802;
    localparam int unsigned K_BCB = 116130;

    // Forward path coefficients
    localparam int unsigned K_YR  = 19595;
    localparam int unsigned K_YG  = 38470;
    localparam int unsigned K_YB  = 7471;
    localparam int unsigned K_CBR = 11059;
    localparam int unsigned K_CBG = 21709;
    localparam int unsigned K_CBB = 32768;
    localparam int unsigned K_CRR = 32768;
    localparam int unsigned K_CRG = 27439;
    localparam int unsigned K_CRB = 5329;

    // Re-express a Q16 coefficient at another fractional precision (rounded).
    function automatic int unsigned rescale_k(input int unsigned k16, input int unsigned scale);
        if (scale >= K_SCALE)
            return k16 << (scale - K_SCALE);
        return (k16 + (1 << (K_SCALE - scale - 1))) >> (K_SCALE - scale);
    endfunction

    function automatic int unsigned round_half(input int unsigned scale);
        return 1 << (scale - 1);
    endfunction

endpackage

// File: rtl/ycbcr_to_rgb_csd_if.sv
// Sample-in / pixel-out valid-ready bundle for ycbcr_to_rgb_csd.
// sat_flag exists only when YCC2RGB_SAT_FLAG_EN is defined.
interface ycbcr_to_rgb_csd_if #(
    parameter int unsigned FIXED_POINT_LENGTH = 32,
    parameter int unsigned OUTPUT_WIDTH       = 8
);
    logic                          in_valid;
    logic                          in_ready;
    logic [FIXED_POINT_LENGTH-1:0] y_in;
    logic [FIXED_POINT_LENGTH-1:0] cb_in;
    logic [FIXED_POINT_LENGTH-1:0] cr_in;
    logic                          out_valid;
    logic                          out_ready;
    logic [OUTPUT_WIDTH-1:0]       r_out;
    logic [OUTPUT_WIDTH-1:0]       g_out;
    logic [OUTPUT_WIDTH-1:0]       b_out;
`ifdef YCC2RGB_SAT_FLAG_EN
    logic                          sat_flag;
`endif

    modport slave (
        input  in_valid, y_in, cb_in, cr_in, out_ready,
        output in_ready, out_valid, r_out, g_out, b_out
`ifdef YCC2RGB_SAT_FLAG_EN
        , output sat_flag
`endif
    );

    modport master (
        output in_valid, y_in, cb_in, cr_in, out_ready,
        input  in_ready, out_valid, r_out, g_out, b_out
`ifdef YCC2RGB_SAT_FLAG_EN
        , input sat_flag
`endif
    );

endinterface

// File: rtl/csd_const_mult.sv
// Combinational multiply of a signed operand by a compile-time constant K,
// built as shift-add/subtract terms from K's canonical-signed-digit recoding.
module csd_const_mult #(
    parameter int unsigned IN_W  = 33,
    parameter int unsigned K     = 1,
    parameter int unsigned OUT_W = IN_W + $clog2(K + 1) + 1
) (
    input  logic signed [IN_W-1:0]  x,
    output logic signed [OUT_W-1:0] p
);
    localparam int unsigned KW = $clog2(K + 1) + 1;

    // Non-adjacent form: runs of ones become +2^(n) -2^(m), which needs one spare digit.
    function automatic logic [KW-1:0] csd_digits(input int unsigned k, input logic want_pos);
        logic [KW-1:0]   d;
        longint unsigned r;
        d = '0;
        r = 64'(k);
        for (int unsigned i = 0; i < KW; i++) begin
            if (r[0]) begin
                if (r[1]) begin
                    if (!want_pos) d[i] = 1'b1;
                    r = r + 64'd1;
                end else begin
                    if (want_pos) d[i] = 1'b1;
                    r = r - 64'd1;
                end
            end
            r = r >> 1;
        end
        return d;
    endfunction

    localparam logic [KW-1:0] POS = csd_digits(K, 1'b1);
    localparam logic [KW-1:0] NEG = csd_digits(K, 1'b0);

    logic signed [OUT_W-1:0] x_ext;
    logic signed [OUT_W-1:0] acc;

    assign x_ext = {{(OUT_W - IN_W){x[IN_W-1]}}, x};

    always_comb begin
        acc = '0;
        for (int unsigned i = 0; i < KW; i++) begin
            if (POS[i]) acc = acc + (x_ext <<< i);
            if (NEG[i]) acc = acc - (x_ext <<< i);
        end
    end

    assign p = acc;

endmodule

// File: rtl/ycbcr_to_rgb_csd.sv
// YCbCr (Q.SCALE, full range) -> 8-bit RGB, 3-stage valid/ready pipeline with CSD multipliers.
// Define YCC2RGB_SAT_FLAG_EN to add the registered clamp-detect output sat_flag.
module ycbcr_to_rgb_csd
    import ycbcr_pkg::*;
#(
    parameter int unsigned SCALE              = 16,
    parameter int unsigned FIXED_POINT_LENGTH = 32,
    parameter int unsigned OUTPUT_WIDTH       = 8
) (
    input logic               clk,
    input logic               rst,
    ycbcr_to_rgb_csd_if.slave bus
);
    localparam int unsigned D_W    = FIXED_POINT_LENGTH + 1;
    localparam int unsigned KR     = rescale_k(K_RCR, SCALE);
    localparam int unsigned KGB    = rescale_k(K_GCB, SCALE);
    localparam int unsigned KGR    = rescale_k(K_GCR, SCALE);
    localparam int unsigned KBB    = rescale_k(K_BCB, SCALE);
    localparam int unsigned PROD_W = D_W + $clog2(KBB + 1) + 1;

    localparam logic [D_W-1:0]           OFFSET_Q = D_W'(CHROMA_OFFSET) << SCALE;
    localparam logic signed [PROD_W-1:0] RND      = PROD_W'(round_half(SCALE));
    localparam logic signed [PROD_W-1:0] OUT_MAX  = PROD_W'((64'd1 << OUTPUT_WIDTH) - 64'd1);

    logic                          en;
    logic                          v1_q, v1_d, v2_q, v2_d, out_valid_q, out_valid_d;
    logic [FIXED_POINT_LENGTH-1:0] y1_q, y1_d, y2_q, y2_d;
    logic signed [D_W-1:0]         dcb1_q, dcb1_d, dcr1_q, dcr1_d;
    logic signed [PROD_W-1:0]      p_rcr, p_gcb, p_gcr, p_bcb;
    logic signed [PROD_W-1:0]      p_rcr2_q, p_rcr2_d, p_gcb2_q, p_gcb2_d;
    logic signed [PROD_W-1:0]      p_gcr2_q, p_gcr2_d, p_bcb2_q, p_bcb2_d;
    logic signed [PROD_W-1:0]      y_ext, r_sum, g_sum, b_sum;
    logic [OUTPUT_WIDTH-1:0]       r_q, r_d, g_q, g_d, b_q, b_d;
`ifdef YCC2RGB_SAT_FLAG_EN
    logic                          sat_q, sat_d;
`endif

    function automatic logic [OUTPUT_WIDTH-1:0] clamp(input logic signed [PROD_W-1:0] v);
        if (v[PROD_W-1]) return '0;
        if (v > OUT_MAX) return '1;
        return v[OUTPUT_WIDTH-1:0];
    endfunction

`ifdef YCC2RGB_SAT_FLAG_EN
    function automatic logic clamped(input logic signed [PROD_W-1:0] v);
        return v[PROD_W-1] || (v > OUT_MAX);
    endfunction
`endif

    csd_const_mult #(.IN_W(D_W), .K(KR),  .OUT_W(PROD_W)) u_mul_rcr (.x(dcr1_q), .p(p_rcr));
    csd_const_mult #(.IN_W(D_W), .K(KGB), .OUT_W(PROD_W)) u_mul_gcb (.x(dcb1_q), .p(p_gcb));
    csd_const_mult #(.IN_W(D_W), .K(KGR), .OUT_W(PROD_W)) u_mul_gcr (.x(dcr1_q), .p(p_gcr));
    csd_const_mult #(.IN_W(D_W), .K(KBB), .OUT_W(PROD_W)) u_mul_bcb (.x(dcb1_q), .p(p_bcb));

    // One enable for every stage: the whole pipe freezes while the output is stalled.
    always_comb begin
        en          = bus.out_ready || !out_valid_q;
        v1_d        = v1_q;
        y1_d        = y1_q;
        dcb1_d      = dcb1_q;
        dcr1_d      = dcr1_q;
        v2_d        = v2_q;
        y2_d        = y2_q;
        p_rcr2_d    = p_rcr2_q;
        p_gcb2_d    = p_gcb2_q;
        p_gcr2_d    = p_gcr2_q;
        p_bcb2_d    = p_bcb2_q;
        out_valid_d = out_valid_q;
        if (en) begin
            v1_d        = bus.in_valid;
            y1_d        = bus.y_in;
            dcb1_d      = $signed({1'b0, bus.cb_in} - OFFSET_Q);
            dcr1_d      = $signed({1'b0, bus.cr_in} - OFFSET_Q);
            v2_d        = v1_q;
            y2_d        = y1_q;
            p_rcr2_d    = p_rcr;
            p_gcb2_d    = p_gcb;
            p_gcr2_d    = p_gcr;
            p_bcb2_d    = p_bcb;
            out_valid_d = v2_q;
        end
    end

    // Products return to Q.SCALE (floor) before summing; the final shift rounds half up.
    always_comb begin
        y_ext = $signed(PROD_W'(y2_q));
        r_sum = (y_ext + (p_rcr2_q >>> SCALE) + RND) >>> SCALE;
        g_sum = (y_ext - (p_gcb2_q >>> SCALE) - (p_gcr2_q >>> SCALE) + RND) >>> SCALE;
        b_sum = (y_ext + (p_bcb2_q >>> SCALE) + RND) >>> SCALE;
        r_d   = r_q;
        g_d   = g_q;
        b_d   = b_q;
`ifdef YCC2RGB_SAT_FLAG_EN
        sat_d = sat_q;
`endif
        if (en && v2_q) begin
            r_d   = clamp(r_sum);
            g_d   = clamp(g_sum);
            b_d   = clamp(b_sum);
`ifdef YCC2RGB_SAT_FLAG_EN
            sat_d = clamped(r_sum) || clamped(g_sum) || clamped(b_sum);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q        <= 1'b0;
            y1_q        <= '0;
            dcb1_q      <= '0;
            dcr1_q      <= '0;
            v2_q        <= 1'b0;
            y2_q        <= '0;
            p_rcr2_q    <= '0;
            p_gcb2_q    <= '0;
            p_gcr2_q    <= '0;
            p_bcb2_q    <= '0;
            out_valid_q <= 1'b0;
            r_q         <= '0;
            g_q         <= '0;
            b_q         <= '0;
`ifdef YCC2RGB_SAT_FLAG_EN
            sat_q       <= 1'b0;
`endif
        end else begin
            v1_q        <= v1_d;
            y1_q        <= y1_d;
            dcb1_q      <= dcb1_d;
            dcr1_q      <= dcr1_d;
            v2_q        <= v2_d;
            y2_q        <= y2_d;
            p_rcr2_q    <= p_rcr2_d;
            p_gcb2_q    <= p_gcb2_d;
            p_gcr2_q    <= p_gcr2_d;
            p_bcb2_q    <= p_bcb2_d;
            out_valid_q <= out_valid_d;
            r_q         <= r_d;
            g_q         <= g_d;
            b_q         <= b_d;
`ifdef YCC2RGB_SAT_FLAG_EN
            sat_q       <= sat_d;
`endif
        end
    end

    assign bus.in_ready  = en;
    assign bus.out_valid = out_valid_q;
    assign bus.r_out     = r_q;
    assign bus.g_out     = g_q;
    assign bus.b_out     = b_q;
`ifdef YCC2RGB_SAT_FLAG_EN
    assign bus.sat_flag  = sat_q;
`endif

endmodule
